// File: rtl/machine_seq_ctrl_pkg.sv
// Shared types and widths for the machine sequence controller.
// The optional f_trace feature is enabled by MACHINE_SEQ_CTRL_TRACE_EN.
package machine_pkg;

  localparam int PAT_W = 16;
  localparam int LEN_W = 5;
  localparam int MS_W  = 3;
  localparam int IDX_W = $clog2(PAT_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/machine_seq_ctrl_if.sv
// Host-side bus of machine_seq_ctrl: request, status and results.
// f_trace exists only when MACHINE_SEQ_CTRL_TRACE_EN is defined.
interface machine_seq_ctrl_if;
  import machine_pkg::*;

  // start is a request accepted only while the controller is idle (busy=0, done=0);
  // pattern and len are captured on that same edge and ignored afterwards.
  logic              start;
  logic [PAT_W-1:0]  pattern;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  f_count;
  logic [MS_W-1:0]   last_state;
`ifdef MACHINE_SEQ_CTRL_TRACE_EN
  logic [PAT_W-1:0]  f_trace;

  modport master (output start, pattern, len,
                  input  busy, done, f_count, last_state, f_trace);
  modport slave  (input  start, pattern, len,
                  output busy, done, f_count, last_state, f_trace);
`else
  modport master (output start, pattern, len,
                  input  busy, done, f_count, last_state);
  modport slave  (input  start, pattern, len,
                  output busy, done, f_count, last_state);
`endif

endinterface

// File: rtl/machine_seq_ctrl_seq_bit_counter.sv
// Bit index for the SHIFT phase, with len clamped to 1..16 at load time.
module seq_bit_counter
  import machine_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] len_m1_d;
  logic [IDX_W-1:0] len_m1_q;

  // Stored as len-1 so the full 16-bit run fits a 4-bit compare.
  always_comb begin
    len_m1_d = '0;
    if (len > LEN_W'(PAT_W))
      len_m1_d = IDX_W'(PAT_W - 1);
    else if (len != '0)
      len_m1_d = IDX_W'(len - LEN_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      len_m1_q <= '0;
    end else if (load) begin
      idx      <= '0;
      len_m1_q <= len_m1_d;
    end else if (advance) begin
      idx <= idx + IDX_W'(1);
    end
  end

  assign last = (idx == len_m1_q);

endmodule

// File: rtl/machine_seq_ctrl.sv
// Sequencer that resets an external 3-bit machine, shifts a bit pattern into it and
// counts its F outputs. Defining MACHINE_SEQ_CTRL_TRACE_EN adds the f_trace record.
module machine_seq_ctrl
  import machine_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  machine_seq_ctrl_if.slave bus,
  input  logic              f_in,
  input  logic [MS_W-1:0]   s_in,
  output logic              x_out,
  output logic              mach_rst,
  output state_e            dbg_state
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] f_count_q;
  logic [MS_W-1:0]  last_state_q;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             accept;
  logic             sample;
  logic [IDX_W-1:0] sample_idx;

  assign accept = (state_q == ST_IDLE) && bus.start;

  // F reflects the previous x, so SHIFT cycle 0 has nothing to sample and DRAIN takes the last one.
  assign sample     = ((state_q == ST_SHIFT) && (idx != '0)) || (state_q == ST_DRAIN);
  assign sample_idx = (state_q == ST_SHIFT) ? idx - IDX_W'(1) : idx;

  seq_bit_counter u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .len     (bus.len),
    .advance ((state_q == ST_SHIFT) && !last),
    .idx     (idx),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    x_out   = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        x_out = pat_q[idx];
        if (last) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The controlled machine stays in reset whenever the controller does.
  assign mach_rst  = rst || (state_q == ST_LOAD);
  assign bus.busy  = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  assign bus.done  = (state_q == ST_DONE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q        <= '0;
      f_count_q    <= '0;
      last_state_q <= '0;
    end else begin
      if (accept) begin
        pat_q     <= bus.pattern;
        f_count_q <= '0;
      end else if (sample && f_in) begin
        f_count_q <= f_count_q + LEN_W'(1);
      end
      if (state_q == ST_DRAIN) last_state_q <= s_in;
    end
  end

  assign bus.f_count    = f_count_q;
  assign bus.last_state = last_state_q;

`ifdef MACHINE_SEQ_CTRL_TRACE_EN
  logic [PAT_W-1:0] trace_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  trace_q <= '0;
    else if (accept)          trace_q <= '0;
    else if (sample)          trace_q[sample_idx] <= f_in;
  end

  assign bus.f_trace = trace_q;
`else
  logic unused_sample_idx;
  assign unused_sample_idx = ^sample_idx;
`endif

endmodule

// File: tb/tb_machine_seq_ctrl.sv
// Bench for machine_seq_ctrl driving a behavioural 3-bit controlled machine;
// set MACHINE_SEQ_CTRL_TRACE_EN to also check f_trace.
module tb_machine_seq_ctrl;
  import machine_pkg::*;

`ifdef MACHINE_SEQ_CTRL_TRACE_EN
  localparam int W = 24;
`else
  localparam int W = 8;
`endif

  logic            clk;
  logic            rst;
  logic            x_out;
  logic            mach_rst;
  logic            f_in;
  logic [2:0]      s_in;
  logic [2:0]      plant_s;
  state_e          dbg_state;
  int              checks = 0;
  int              errors = 0;
  logic [W-1:0]    exp_q[$];

  machine_seq_ctrl_if bus ();

  machine_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .f_in      (f_in),
    .s_in      (s_in),
    .x_out     (x_out),
    .mach_rst  (mach_rst),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- controlled machine ----------------
  // x=1 returns to 000; x=0 walks 000->010->011->111->110 and parks at 110. F = s[2].
  function automatic logic [2:0] plant_next(input logic [2:0] s, input logic x);
    if (x) return 3'b000;
    case (s)
      3'b000:  return 3'b010;
      3'b010:  return 3'b011;
      3'b011:  return 3'b111;
      3'b111:  return 3'b110;
      3'b110:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge mach_rst) begin
    if (mach_rst) plant_s <= 3'b000;
    else          plant_s <= plant_next(plant_s, x_out);
  end

  assign s_in = plant_s;
  assign f_in = plant_s[2];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] pat, input int l,
                       output logic [4:0] fc, output logic [2:0] ls, output logic [15:0] tr);
    logic [2:0] s;
    s  = 3'b000;
    fc = '0;
    tr = '0;
    for (int i = 0; i < l; i++) begin
      s     = plant_next(s, pat[i]);
      tr[i] = s[2];
      fc    = fc + {4'b0, s[2]};
    end
    ls = s;
  endtask

  // scoreboard: every done pulse consumes one expected result
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(bus.done), 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
`ifdef MACHINE_SEQ_CTRL_TRACE_EN
        check("sb_result", 32'({bus.f_trace, bus.last_state, bus.f_count}), 32'(e));
`else
        check("sb_result", 32'({bus.last_state, bus.f_count}), 32'(e));
`endif
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_seq(input logic [15:0] pat, input logic [4:0] len_in, input bit hold);
    int         l;
    logic [4:0] fc;
    logic [2:0] ls;
    logic [15:0] tr;
    logic       exp_x;
    state_e     exp_st;
    l = (len_in == 5'd0) ? 1 : (len_in > 5'd16) ? 16 : int'(len_in);
    model(pat, l, fc, ls, tr);
`ifdef MACHINE_SEQ_CTRL_TRACE_EN
    exp_q.push_back({tr, ls, fc});
`else
    exp_q.push_back({ls, fc});
`endif
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = len_in;
    for (int j = 1; j <= l + 3; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 1) begin
        if (!hold) bus.start = 1'b0;
        bus.pattern = ~pat;
        bus.len     = 5'($urandom_range(0, 31));
`ifdef MACHINE_SEQ_CTRL_TRACE_EN
        check("trace_clear", 32'(bus.f_trace), 32'd0);
`endif
        check("count_clear", 32'(bus.f_count), 32'd0);
      end
      exp_x  = (j >= 2 && j <= l + 1) ? pat[j-2] : 1'b0;
      exp_st = (j == 1) ? ST_LOAD : (j <= l + 1) ? ST_SHIFT : (j == l + 2) ? ST_DRAIN : ST_DONE;
      check("x_out",    32'(x_out),     32'(exp_x));
      check("busy",     32'(bus.busy),  32'(j <= l + 2));
      check("done",     32'(bus.done),  32'(j == l + 3));
      check("mach_rst", 32'(mach_rst),  32'(j == 1));
      check("state",    32'(dbg_state), 32'(exp_st));
    end
    @(posedge clk);
    @(negedge clk);
    check("idle_state",      32'(dbg_state),      32'(ST_IDLE));
    check("idle_done",       32'(bus.done),       32'd0);
    check("hold_f_count",    32'(bus.f_count),    32'(fc));
    check("hold_last_state", 32'(bus.last_state), 32'(ls));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},      32'(dbg_state),      32'(ST_IDLE));
    check({tag, "_x_out"},      32'(x_out),          32'd0);
    check({tag, "_mach_rst"},   32'(mach_rst),       32'd1);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_done"},       32'(bus.done),       32'd0);
    check({tag, "_f_count"},    32'(bus.f_count),    32'd0);
    check({tag, "_last_state"}, 32'(bus.last_state), 32'd0);
`ifdef MACHINE_SEQ_CTRL_TRACE_EN
    check({tag, "_f_trace"},    32'(bus.f_trace),    32'd0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_seq(16'h0000, 5'd4,  1'b0);
    run_seq(16'h0000, 5'd16, 1'b0);
    run_seq(16'hFFFF, 5'd16, 1'b0);
    run_seq(16'h0000, 5'd0,  1'b0);
    run_seq(16'($urandom), 5'd20, 1'b0);
    run_seq(16'hF0F0, 5'd9,  1'b0);
    run_seq(16'($urandom), 5'($urandom_range(1, 16)), 1'b0);

    // abort in SHIFT cycle 5 of an 8-bit run
    bus.start   = 1'b1;
    bus.pattern = 16'h0000;
    bus.len     = 5'd8;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 1) bus.start = 1'b0;
    end
    check("abort_pre_state",   32'(dbg_state),   32'(ST_SHIFT));
    check("abort_pre_f_count", 32'(bus.f_count), 32'd2);
    rst = 1'b1;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
      check("abort_idle",    32'(dbg_state), 32'(ST_IDLE));
    end
    run_seq(16'h0000, 5'd4, 1'b0);

    // start held through a whole run, then honoured again right after DONE
    run_seq(16'h00A5, 5'd6, 1'b1);
    run_seq(16'h0003, 5'd5, 1'b0);
    repeat (3) @(negedge clk);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/machine_seq_ctrl.md
MACHINE_SEQ_CTRL -- requirements
Module: machine_seq_ctrl

Interface
REQ-001 CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  request to run one sequence; sampled in IDLE only.
REQ-004 pattern  input  16  serial x stream, bit 0 applied first.
REQ-005 len  input  5  number of bits to apply; valid range 1..16.
REQ-006 f_in  input  1  F output of the controlled 3-bit JK state machine.
REQ-007 s_in  input  3  S output of the controlled state machine.
REQ-008 x_out  output  1  drives the controlled machine's x input.
REQ-009 mach_rst  output  1  drives the controlled machine's reset input.
REQ-010 busy  output  1  high from start acceptance until done.
REQ-011 done  output  1  single-cycle completion pulse.
REQ-012 f_count  output  5  number of F=1 samples in the last sequence.
REQ-013 last_state  output  3  s_in captured at sequence end.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, SHIFT, DRAIN and DONE.
REQ-015 In IDLE, start=1 SHALL latch pattern and len, clear f_count, and go to LOAD.
REQ-016 A latched len of 0 SHALL be treated as 1; len values 17..31 SHALL be clamped to 16.
REQ-017 In LOAD (exactly 1 cycle), mach_rst SHALL be 1; the next state SHALL be SHIFT with bit index 0.
REQ-018 In SHIFT cycle k (k=0..len-1), x_out SHALL equal pattern[k]; after cycle len-1 the FSM SHALL go to DRAIN.
REQ-019 f_in SHALL be sampled in SHIFT cycles k=1..len-1 and in the DRAIN cycle, giving exactly len samples; each sample of 1 increments f_count (max 16, no overflow possible).
REQ-020 In DRAIN (1 cycle), x_out SHALL be 0 and last_state SHALL capture s_in at the end of the cycle.
REQ-021 DONE SHALL last 1 cycle with done=1 and busy=0, then go to IDLE.
REQ-022 busy SHALL be 1 in LOAD, SHIFT and DRAIN only.
REQ-023 start SHALL be ignored outside IDLE, and pattern/len changes SHALL have no effect after latching.
REQ-024 f_count and last_state SHALL hold their values in IDLE until the next accepted start.
REQ-025 x_out SHALL be 0 and mach_rst SHALL be 0 in every state except those given above.

Reset
REQ-026 RESET=1 SHALL immediately force IDLE, x_out=0, mach_rst=1, busy=0, done=0, f_count=0 and last_state=0.
REQ-027 mach_rst SHALL follow RESET combinationally OR the LOAD term, so that the controlled machine is held in reset together with the controller.
REQ-028 RESET asserted mid-sequence SHALL abort the sequence without a done pulse.

Configuration
REQ-029 With macro MACHINE_SEQ_CTRL_TRACE_EN defined, the module SHALL add output f_trace[15:0]; sample i of f_in is stored in bit i, unsampled bits are 0, and the whole vector is cleared on start acceptance and on reset.
REQ-030 Without MACHINE_SEQ_CTRL_TRACE_EN, the f_trace port and its register SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package machine_pkg SHALL hold the FSM state enum, the pattern width (16), the len width (5) and the machine state width (3).
REQ-032 A single sub-module seq_bit_counter SHALL hold the bit index, the terminal-count compare and the len clamp.
REQ-033 The controller SHALL NOT instantiate the state machine; the bench SHALL connect the two at top level.

Verification
REQ-034 pattern=0x0000, len=4 -> samples 0,0,1,1; f_count=2; last_state=3'b110; done pulses 7 cycles after start.
REQ-035 pattern=0x0000, len=16 -> f_count=14; last_state=3'b110.
REQ-036 pattern=0xFFFF, len=16 -> f_count=0; last_state=3'b000; x_out is 1 for 16 consecutive cycles.
REQ-037 len=0 -> run treated as len=1; pattern=0x0000 -> f_count=0; last_state=3'b010.
REQ-038 RESET asserted in SHIFT cycle 5 -> immediate IDLE, no done pulse, outputs at reset values; the next start runs normally.
REQ-039 start held high through the entire run -> only one sequence runs; a second start accepted in the cycle after DONE is honoured.
